// File: rtl/imem_program_loader.sv
// Debug-side loader: decodes UART command bytes, streams program bytes into
// instruction memory and gates the fetch-stage halt line for run/step.
module imem_program_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD   = 8'h4C,
  parameter logic [7:0]  CMD_RUN    = 8'h43,
  parameter logic [7:0]  CMD_STEP   = 8'h53
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_cpu_halted,
  output logic        o_write_instruction_mem,
  output logic [31:0] o_instruction_mem_addr,
  output logic [31:0] o_instruction_mem_data,
  output logic        o_halt,
  output logic        o_pipeline_reset,
  output logic        o_load_done,
  output logic        o_load_error,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STEP = 2'd3
  } state_t;

  // One extra bit lets the counter reach 2^ADDR_WIDTH without wrapping.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state;
  logic [ADDR_WIDTH:0] count;
  logic [31:0]         word;

  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                   <= IDLE;
      count                   <= '0;
      word                    <= '0;
      o_write_instruction_mem <= 1'b0;
      o_instruction_mem_addr  <= '0;
      o_instruction_mem_data  <= '0;
      o_halt                  <= 1'b1;
      o_pipeline_reset        <= 1'b0;
      o_load_done             <= 1'b0;
      o_load_error            <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so every branch below only
      // has to raise them; non-blocking keeps the later assignment winning.
      o_write_instruction_mem <= 1'b0;
      o_pipeline_reset        <= 1'b0;

      unique case (state)
        IDLE: begin
          o_halt <= 1'b1;
          if (i_rx_valid) begin
            if (i_rx_data == CMD_LOAD) begin
              state        <= LOAD;
              count        <= '0;
              word         <= '0;
              o_load_done  <= 1'b0;
              o_load_error <= 1'b0;
            end else if (i_rx_data == CMD_RUN && o_load_done && !i_cpu_halted) begin
              state  <= RUN;
              o_halt <= 1'b0;
            end else if (i_rx_data == CMD_STEP && o_load_done && !i_cpu_halted) begin
              state  <= STEP;
              o_halt <= 1'b0;
            end
          end
        end

        LOAD: begin
          o_halt <= 1'b1;
          // A completed HALT word wins over a full memory.
          if (count[1:0] == 2'b00 && word == HALT_WORD) begin
            o_load_done      <= 1'b1;
            o_pipeline_reset <= 1'b1;
            state            <= IDLE;
          end else if (count == MEM_BYTES) begin
            o_load_error <= 1'b1;
            state        <= IDLE;
          end else if (i_rx_valid) begin
            o_write_instruction_mem <= 1'b1;
            o_instruction_mem_addr  <= 32'(count[ADDR_WIDTH-1:0]);
            o_instruction_mem_data  <= {24'b0, i_rx_data};
            count                   <= count + 1'b1;
            word                    <= {word[23:0], i_rx_data};
          end
        end

        RUN: begin
          if (i_cpu_halted) begin
            o_halt <= 1'b1;
            state  <= IDLE;
          end else begin
            o_halt <= 1'b0;
          end
        end

        STEP: begin
          o_halt <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: load, run, step, refusal,
// memory-full error, end-of-memory HALT word and reset during load.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        cpu_halted;
  logic        write_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        halt;
  logic        pipeline_reset;
  logic        load_done;
  logic        load_error;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  imem_program_loader dut (
    .i_clk                  (clk),
    .i_reset                (reset),
    .i_rx_data              (rx_data),
    .i_rx_valid             (rx_valid),
    .i_cpu_halted           (cpu_halted),
    .o_write_instruction_mem(write_mem),
    .o_instruction_mem_addr (mem_addr),
    .o_instruction_mem_data (mem_data),
    .o_halt                 (halt),
    .o_pipeline_reset       (pipeline_reset),
    .o_load_done            (load_done),
    .o_load_error           (load_error),
    .o_state                (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte for exactly one edge; outputs reflect that edge on return.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] prog [8];
  logic       preset_seen;

  initial begin
    prog = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; cpu_halted = 1'b0;
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();

    // Reset / idle state
    check("rst_halt",  32'(halt), 32'd1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_write", 32'(write_mem), 32'd0);
    check("rst_done",  32'(load_done), 32'd0);
    check("rst_error", 32'(load_error), 32'd0);
    check("rst_addr",  mem_addr, 32'd0);

    // RUN before any load is refused
    send(8'h43);
    check("norun_state", 32'(state), 32'd0);
    check("norun_halt",  32'(halt), 32'd1);

    // Load the 8-byte program back-to-back
    send(8'h4C);
    check("load_state", 32'(state), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send(prog[i]);
      check($sformatf("ld_wr%0d", i),   32'(write_mem), 32'd1);
      check($sformatf("ld_addr%0d", i), mem_addr, 32'(i));
      check($sformatf("ld_data%0d", i), mem_data, {24'b0, prog[i]});
      check($sformatf("ld_halt%0d", i), 32'(halt), 32'd1);
    end
    tick();
    check("ld_done",   32'(load_done), 32'd1);
    check("ld_preset", 32'(pipeline_reset), 32'd1);
    check("ld_state",  32'(state), 32'd0);
    check("ld_wr_off", 32'(write_mem), 32'd0);
    tick();
    check("ld_preset_pulse", 32'(pipeline_reset), 32'd0);
    check("ld_done_hold",    32'(load_done), 32'd1);

    // Continuous run until the CPU reports halted
    send(8'h43);
    check("run_state", 32'(state), 32'd2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("run_halt%0d", i), 32'(halt), 32'd0);
      tick();
    end
    cpu_halted = 1'b1;
    tick();
    check("run_end_halt",  32'(halt), 32'd1);
    check("run_end_state", 32'(state), 32'd0);
    check("run_done_keep", 32'(load_done), 32'd1);
    cpu_halted = 1'b0;
    tick();

    // Three single steps, spaced 5 cycles
    for (int s = 0; s < 3; s++) begin
      send(8'h53);
      check($sformatf("step%0d_open", s),  32'(halt), 32'd0);
      check($sformatf("step%0d_state", s), 32'(state), 32'd3);
      tick();
      check($sformatf("step%0d_close", s), 32'(halt), 32'd1);
      check($sformatf("step%0d_idle", s),  32'(state), 32'd0);
      repeat (3) tick();
      check($sformatf("step%0d_held", s),  32'(halt), 32'd1);
    end

    // 256 zero bytes fill memory without a HALT word
    send(8'h4C);
    check("fill_done_clr", 32'(load_done), 32'd0);
    preset_seen = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send(8'h00);
      preset_seen |= pipeline_reset;
      if (i == 0 || i == 127 || i == 255) begin
        check($sformatf("fill_wr%0d", i),   32'(write_mem), 32'd1);
        check($sformatf("fill_addr%0d", i), mem_addr, 32'(i));
      end
    end
    tick();
    preset_seen |= pipeline_reset;
    check("fill_error",  32'(load_error), 32'd1);
    check("fill_done",   32'(load_done), 32'd0);
    check("fill_state",  32'(state), 32'd0);
    check("fill_wr_off", 32'(write_mem), 32'd0);
    send(8'h00);
    preset_seen |= pipeline_reset;
    check("fill_no_wrap", 32'(write_mem), 32'd0);
    check("fill_preset",  32'(preset_seen), 32'd0);
    send(8'h43);
    check("fill_norun", 32'(state), 32'd0);

    // HALT word in the last four bytes: done wins over error
    send(8'h4C);
    for (int i = 0; i < 252; i++) send(8'h00);
    for (int i = 0; i < 4; i++) send(8'hFF);
    check("edge_addr", mem_addr, 32'd255);
    check("edge_data", mem_data, 32'h0000_00FF);
    tick();
    check("edge_done",   32'(load_done), 32'd1);
    check("edge_error",  32'(load_error), 32'd0);
    check("edge_preset", 32'(pipeline_reset), 32'd1);

    // Reset during a load after 3 bytes
    send(8'h4C);
    send(8'h11); send(8'h22); send(8'h33);
    check("mid_wr_before", 32'(write_mem), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_state", 32'(state), 32'd0);
    check("mid_write", 32'(write_mem), 32'd0);
    check("mid_addr",  mem_addr, 32'd0);
    check("mid_done",  32'(load_done), 32'd0);
    check("mid_halt",  32'(halt), 32'd1);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
